nco_core: RTL and testbench

//  Numerically controlled oscillator: an ACC_W-bit phase accumulator advances by

---
 rtl/nco_pkg.sv | 27 ++
 rtl/nco_sin_lut.sv | 28 ++
 rtl/nco_core.sv | 57 +++++
 tb/tb_nco_core.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants for the NCO: quarter-wave sine table and LUT offsets.
// Optional feature macro used by nco_core: NCO_PHASE_OFS_EN (phase offset input).
package nco_pkg;

  localparam int QTR_DEPTH = 65;

  // Mid-scale of the offset-binary output and the quarter-turn cosine shift
  localparam logic [7:0] MID        = 8'd128;
  localparam logic [7:0] QUAD_SHIFT = 8'd64;

  // Cosine value at phase 0, used as its reset value
  localparam logic [7:0] COS_RST    = 8'd255;

  // Q[k] = round(127*sin(pi*k/128)), k = 0..64
  localparam logic [7:0] QTR_TABLE [0:QTR_DEPTH-1] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
    8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
    8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
    8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
    8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
    8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127,
    8'd127
  };

endpackage

// File: rtl/nco_sin_lut.sv
// Combinational full-wave sine lookup built from the quarter-wave table:
// fold the phase into the first quadrant, read the magnitude, apply sign and
// offset to produce an offset-binary sample in 1..255.
module nco_sin_lut
  import nco_pkg::*;
(
  input  logic [7:0] phase,
  output logic [7:0] sample
);

  logic [6:0] qtr_addr;
  logic [7:0] magnitude;

  // Quadrant fold: odd quadrants read the table mirrored, upper half negates
  always_comb begin
    qtr_addr  = {1'b0, phase[5:0]};
    if (phase[6]) begin
      qtr_addr = 7'd64 - {1'b0, phase[5:0]};
    end
    magnitude = QTR_TABLE[qtr_addr];
    if (phase[7]) begin
      sample = MID - magnitude;
    end else begin
      sample = MID + magnitude;
    end
  end

endmodule

// File: rtl/nco_core.sv
// Numerically controlled oscillator: phase accumulator feeding two sine LUTs
// (sine at p, cosine at p+64) with registered 8-bit offset-binary outputs.
// Optional macro NCO_PHASE_OFS_EN adds a phase_ofs input added to the LUT address.
module nco_core
  import nco_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] phase_inc,
`ifdef NCO_PHASE_OFS_EN
  input  logic [7:0]       phase_ofs,
`endif
  output logic [7:0]       sine_out,
  output logic [7:0]       cosine_out
);

  logic [ACC_W-1:0] acc_reg;
  logic [7:0]       lut_addr;
  logic [7:0]       lut_phase  [2];
  logic [7:0]       lut_sample [2];

`ifdef NCO_PHASE_OFS_EN
  // Offset shifts both LUT addresses equally so quadrature is kept
  assign lut_addr = acc_reg[ACC_W-1 -: 8] + phase_ofs;
`else
  assign lut_addr = acc_reg[ACC_W-1 -: 8];
`endif

  // Index 0 is sine, index 1 is cosine (a quarter turn ahead)
  assign lut_phase[0] = lut_addr;
  assign lut_phase[1] = lut_addr + QUAD_SHIFT;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lut
      nco_sin_lut u_lut (
        .phase  (lut_phase[gi]),
        .sample (lut_sample[gi])
      );
    end
  endgenerate

  // Accumulate phase (silent wrap) and register samples of the pre-update phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg    <= '0;
      sine_out   <= MID;
      cosine_out <= COS_RST;
    end else begin
      acc_reg    <= acc_reg + phase_inc;
      sine_out   <= lut_sample[0];
      cosine_out <= lut_sample[1];
    end
  end

endmodule

// File: tb/tb_nco_core.sv
// Self-checking bench for nco_core: directed tests plus random phase steps,
// compared against a floating-point sine reference and an integer phase model.
`timescale 1ns/1ps
module tb_nco_core;

  localparam int ACC_W = 8;
  localparam longint ACC_MOD = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [ACC_W-1:0] phase_inc;
  logic [7:0]       sine_out;
  logic [7:0]       cosine_out;
`ifdef NCO_PHASE_OFS_EN
  logic [7:0]       phase_ofs;
`endif

  int     errors = 0;
  int     checks = 0;
  longint model_acc = 0;
  int     model_ofs = 0;

  nco_core #(.ACC_W(ACC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .phase_inc  (phase_inc),
`ifdef NCO_PHASE_OFS_EN
    .phase_ofs  (phase_ofs),
`endif
    .sine_out   (sine_out),
    .cosine_out (cosine_out)
  );

  always #5 clk = ~clk;

  // Reference: S(p) = 128 + round(127*sin(2*pi*p/256)), ties away from zero
  function automatic logic [7:0] s_ref(input int p);
    real a;
    real r;
    int  v;
    a = 2.0 * 3.14159265358979 * real'(p % 256) / 256.0;
    r = 127.0 * $sin(a);
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(-r + 0.5);
    return 8'(128 + v);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock out of reset: model phase at the edge, then compare outputs
  task automatic step(input string tag);
    int p;
    @(posedge clk);
    p = (int'(model_acc >> (ACC_W - 8)) + model_ofs) % 256;
    model_acc = (model_acc + longint'(phase_inc)) % ACC_MOD;
    #1;
    $display("%s p=%0d inc=%0d sin=%0d cos=%0d", tag, p, phase_inc, sine_out, cosine_out);
    chk({tag, "_sin"}, sine_out, s_ref(p));
    chk({tag, "_cos"}, cosine_out, s_ref(p + 64));
  endtask

  // One clock with reset held: outputs stay at the reset pair
  task automatic reset_cycle(input string tag);
    @(posedge clk);
    #1;
    $display("%s reset sin=%0d cos=%0d", tag, sine_out, cosine_out);
    chk({tag, "_sin"}, sine_out, 8'd128);
    chk({tag, "_cos"}, cosine_out, 8'd255);
  endtask

  task automatic release_reset(input logic [ACC_W-1:0] inc);
    phase_inc = inc;
    reset     = 1'b1;
    model_acc = 0;
  endtask

  initial begin : main
    logic [7:0] t2_sin [5];
    real        ds;
    real        dc;
    real        rad;
    t2_sin = '{8'd128, 8'd177, 8'd218, 8'd245, 8'd255};

    reset     = 1'b0;
    phase_inc = 'x;
`ifdef NCO_PHASE_OFS_EN
    phase_ofs = 8'd0;
`endif
    #1;

    // 1: reset held with undefined phase_inc
    for (int i = 0; i < 5; i++) reset_cycle("t1");

    // 2: step 0x10 from reset, known sine sequence, 2 full periods
    release_reset(8'h10);
    for (int i = 0; i < 32; i++) begin
      step("t2");
      if (i < 5) chk("t2_const", sine_out, t2_sin[i]);
      if (i == 8)  chk("t2_p128", sine_out, 8'd128);
      if (i == 12) chk("t2_p192", sine_out, 8'd1);
    end

    // 3: three steps of 0x10 then freeze at p=48
    reset = 1'b0;
    #1;
    release_reset(8'h10);
    for (int i = 0; i < 3; i++) step("t3a");
    phase_inc = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step("t3");
      chk("t3_hold_sin", sine_out, 8'd245);
      chk("t3_hold_cos", cosine_out, 8'd177);
    end

    // 4: backwards by one LSB per clock, across the wrap
    reset = 1'b0;
    #1;
    release_reset(8'hFF);
    for (int i = 0; i < 6; i++) begin
      step("t4");
      if (i == 1) chk("t4_p255", sine_out, 8'd125);
      if (i == 2) chk("t4_p254", sine_out, 8'd122);
    end

    // 5: asynchronous reset between edges, then restart as in test 2
    phase_inc = 8'h10;
    for (int i = 0; i < 5; i++) step("t5a");
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_sin", sine_out, 8'd128);
    chk("t5_async_cos", cosine_out, 8'd255);
    reset_cycle("t5r");
    release_reset(8'h10);
    for (int i = 0; i < 5; i++) begin
      step("t5");
      chk("t5_const", sine_out, t2_sin[i]);
    end

    // Random phase steps with occasional mid-run resets
    for (int n = 0; n < 40; n++) begin
      phase_inc = ACC_W'($urandom);
      for (int k = 0, len = $urandom_range(1, 6); k < len; k++) step("rnd");
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        #1;
        reset_cycle("rndr");
        release_reset(ACC_W'($urandom));
      end
    end

    // 6: full sweep with step 1, plus unit-circle check
    reset = 1'b0;
    #1;
    release_reset(8'h01);
    for (int i = 0; i < 256; i++) begin
      step("t6");
      ds  = real'(sine_out) - 128.0;
      dc  = real'(cosine_out) - 128.0;
      rad = $sqrt(ds * ds + dc * dc);
      chk("t6_circle", 8'((rad >= 126.0 && rad <= 128.0) ? 1 : 0), 8'd1);
    end

`ifdef NCO_PHASE_OFS_EN
    // Phase offset of a quarter turn makes sine equal the un-offset cosine
    reset = 1'b0;
    #1;
    release_reset(8'h01);
    phase_ofs = 8'd64;
    model_ofs = 64;
    for (int i = 0; i < 256; i++) begin
      step("ofs");
      chk("ofs_quarter", sine_out, s_ref(i + 64));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
